// File: rtl/regfile_scoreboard.sv
// Integer register file with hardwired zero entry, write-to-read bypass and a
// per-register pending scoreboard for RAW hazard detection in decode.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              busy1,
    output logic              busy2,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   pend_cnt_q, pend_cnt_d;
    logic              wr_zero;
    logic              fwd1, fwd2;

    assign wr_zero = (ZERO_REG != 0) && (waddr == '0);

    always_comb begin
        regs_d = regs_q;
        if (we && !wr_zero) begin
            regs_d[waddr] = wdata;
        end
    end

    // Flush beats a new issue, and a new issue beats a writeback to the same entry.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (flush) begin
                pend_d[i] = 1'b0;
            end else if (sb_set && (sb_addr == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end else if (we && (waddr == ADDR_W'(i))) begin
                pend_d[i] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            pend_d[0] = 1'b0;
        end
    end

    always_comb begin
        pend_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_cnt_d = pend_cnt_d + (ADDR_W + 1)'(pend_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign fwd1 = (BYPASS != 0) && we && (waddr == raddr1) && !wr_zero;
    assign fwd2 = (BYPASS != 0) && we && (waddr == raddr2) && !wr_zero;

    always_comb begin
        if (fwd1) begin
            rdata1 = wdata;
        end else if ((ZERO_REG != 0) && (raddr1 == '0)) begin
            rdata1 = '0;
        end else begin
            rdata1 = regs_q[raddr1];
        end
    end

    always_comb begin
        if (fwd2) begin
            rdata2 = wdata;
        end else if ((ZERO_REG != 0) && (raddr2 == '0)) begin
            rdata2 = '0;
        end else begin
            rdata2 = regs_q[raddr2];
        end
    end

    // A forwarded writeback resolves the hazard in the same cycle.
    assign busy1    = pend_q[raddr1] && !((BYPASS != 0) && we && (waddr == raddr1));
    assign busy2    = pend_q[raddr2] && !((BYPASS != 0) && we && (waddr == raddr2));
    assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: a bypassing and a non-bypassing
// instance share stimulus and are checked every cycle against an array model.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [4:0]  raddr1 = '0;
    logic [4:0]  raddr2 = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_addr = '0;
    logic        flush = 1'b0;

    logic [31:0] rdata1, rdata2, rdata1_nb, rdata2_nb;
    logic        busy1, busy2, busy1_nb, busy2_nb;
    logic [5:0]  pend_cnt, pend_cnt_nb;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .busy1(busy1), .busy2(busy2), .sb_set(sb_set), .sb_addr(sb_addr),
        .flush(flush), .pend_cnt(pend_cnt)
    );

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1_nb), .rdata2(rdata2_nb),
        .busy1(busy1_nb), .busy2(busy2_nb), .sb_set(sb_set), .sb_addr(sb_addr),
        .flush(flush), .pend_cnt(pend_cnt_nb)
    );

    // Reference model: register contents and the set of pending registers.
    bit [31:0] m_regs [32];
    bit [31:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_regs[i]) m_regs[i] = 32'h0;
            m_pend = 32'h0;
        end else begin
            bit [31:0] nxt;
            nxt = m_pend;
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (we) nxt[waddr] = 1'b0;
            if (sb_set) nxt[sb_addr] = 1'b1;
            if (flush) nxt = 32'h0;
            nxt[0] = 1'b0;
            m_pend = nxt;
        end
    end

    function automatic bit [31:0] exp_rd(input bit [4:0] a, input bit byp);
        if (byp && we && waddr == a && waddr != 0) return wdata;
        if (a == 0) return 32'h0;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input bit [4:0] a, input bit byp);
        return m_pend[a] && !(byp && we && waddr == a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    bit run_cmp = 1'b0;
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cmp rdata1", rdata1, exp_rd(raddr1, 1'b1));
            chk("cmp rdata2", rdata2, exp_rd(raddr2, 1'b1));
            chk("cmp busy1", 32'(busy1), 32'(exp_busy(raddr1, 1'b1)));
            chk("cmp busy2", 32'(busy2), 32'(exp_busy(raddr2, 1'b1)));
            chk("cmp pend_cnt", 32'(pend_cnt), $countones(m_pend));
            chk("cmp nb rdata1", rdata1_nb, exp_rd(raddr1, 1'b0));
            chk("cmp nb rdata2", rdata2_nb, exp_rd(raddr2, 1'b0));
            chk("cmp nb busy1", 32'(busy1_nb), 32'(exp_busy(raddr1, 1'b0)));
            chk("cmp nb busy2", 32'(busy2_nb), 32'(exp_busy(raddr2, 1'b0)));
            chk("cmp nb pend_cnt", 32'(pend_cnt_nb), $countones(m_pend));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0;
        sb_set = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset rdata1", rdata1, 32'h0);
        chk("reset busy1", 32'(busy1), 32'h0);
        chk("reset pend_cnt", 32'(pend_cnt), 32'h0);
        run_cmp = 1'b1;
        #10 rst_n = 1'b1;

        for (int a = 0; a < 32; a++) begin
            cyc();
            raddr1 = 5'(a);
            raddr2 = 5'(31 - a);
            #1;
            chk("init rdata1", rdata1, 32'h0);
            chk("init busy2", 32'(busy2), 32'h0);
        end
        chk("init pend_cnt", 32'(pend_cnt), 32'h0);

        // Plain write then read next cycle
        cyc(); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cyc(); idle(); raddr1 = 5'd5; #1;
        chk("x5 read", rdata1, 32'hDEADBEEF);
        chk("x5 read nb", rdata1_nb, 32'hDEADBEEF);

        // Zero register
        cyc(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0; #1;
        chk("x0 same cycle", rdata1, 32'h0);
        cyc(); idle(); sb_set = 1'b1; sb_addr = 5'd0; #1;
        chk("x0 next cycle", rdata1, 32'h0);
        cyc(); idle(); #1;
        chk("x0 busy", 32'(busy1), 32'h0);
        chk("x0 pend_cnt", 32'(pend_cnt), 32'h0);

        // Bypass
        cyc(); we = 1'b1; waddr = 5'd7; wdata = 32'h11;
        cyc(); wdata = 32'h22; raddr2 = 5'd7; #1;
        chk("bypass rdata2", rdata2, 32'h22);
        chk("no bypass rdata2", rdata2_nb, 32'h11);
        cyc(); idle(); #1;
        chk("bypass rdata2 after", rdata2, 32'h22);
        chk("no bypass rdata2 after", rdata2_nb, 32'h22);

        // Scoreboard set / writeback
        cyc(); sb_set = 1'b1; sb_addr = 5'd3; raddr1 = 5'd3; #1;
        chk("sb busy pre-edge", 32'(busy1), 32'h0);
        cyc(); idle(); #1;
        chk("sb busy t+1", 32'(busy1), 32'h1);
        chk("sb pend_cnt t+1", 32'(pend_cnt), 32'h1);
        cyc(); we = 1'b1; waddr = 5'd3; wdata = 32'h33; #1;
        chk("wb busy bypass", 32'(busy1), 32'h0);
        chk("wb busy nb", 32'(busy1_nb), 32'h1);
        chk("wb pend_cnt t+2", 32'(pend_cnt), 32'h1);
        cyc(); idle(); #1;
        chk("wb pend_cnt t+3", 32'(pend_cnt), 32'h0);
        chk("wb busy t+3", 32'(busy1), 32'h0);

        // Set and writeback to the same entry in one cycle
        cyc(); sb_set = 1'b1; sb_addr = 5'd4;
        cyc(); idle(); #1;
        chk("x4 pend_cnt", 32'(pend_cnt), 32'h1);
        cyc(); sb_set = 1'b1; sb_addr = 5'd4; we = 1'b1; waddr = 5'd4; wdata = 32'h44; raddr1 = 5'd4;
        cyc(); idle(); #1;
        chk("x4 still busy", 32'(busy1), 32'h1);
        chk("x4 pend_cnt same", 32'(pend_cnt), 32'h1);
        chk("x4 data", rdata1, 32'h44);
        cyc(); we = 1'b1; waddr = 5'd10; wdata = 32'hA0;
        cyc(); idle(); sb_set = 1'b1; sb_addr = 5'd4;
        cyc(); idle(); #1;
        chk("non-pending wb and re-set", 32'(pend_cnt), 32'h1);

        // Fill the scoreboard, then flush racing a new issue
        for (int i = 1; i < 32; i++) begin
            cyc(); sb_set = 1'b1; sb_addr = 5'(i);
        end
        cyc(); idle(); #1;
        chk("full pend_cnt", 32'(pend_cnt), 32'd31);
        cyc(); flush = 1'b1; sb_set = 1'b1; sb_addr = 5'd9; raddr1 = 5'd9;
        cyc(); idle(); #1;
        chk("flush pend_cnt", 32'(pend_cnt), 32'h0);
        chk("flush busy x9", 32'(busy1), 32'h0);
        for (int a = 0; a < 32; a++) begin
            cyc(); raddr1 = 5'(a); raddr2 = 5'(a ^ 5'h1F);
        end

        // Asynchronous reset mid-sequence
        cyc(); we = 1'b1; waddr = 5'd12; wdata = 32'hABCD; sb_set = 1'b1; sb_addr = 5'd12;
        cyc(); idle(); raddr1 = 5'd12; #1;
        chk("x12 before reset", rdata1, 32'hABCD);
        chk("x12 busy before reset", 32'(busy1), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("async rdata1", rdata1, 32'h0);
        chk("async busy1", 32'(busy1), 32'h0);
        chk("async pend_cnt", 32'(pend_cnt), 32'h0);
        we = 1'b1; waddr = 5'd13; wdata = 32'h1313; sb_set = 1'b1; sb_addr = 5'd13;
        cyc(); idle(); #2 rst_n = 1'b1;
        raddr1 = 5'd13; #1;
        chk("lost write x13", rdata1, 32'h0);
        chk("lost set pend_cnt", 32'(pend_cnt), 32'h0);
        cyc(); we = 1'b1; waddr = 5'd13; wdata = 32'h77;
        cyc(); idle(); #1;
        chk("post reset write", rdata1, 32'h77);
        cyc(); cyc();

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file for the Stage2 decode path, replacing the fixed 32x32 instance. It keeps two combinational read ports and one clocked write port, and adds:
- a hardwired zero entry;
- write-to-read bypass;
- a per-register pending (scoreboard) bit set at issue and cleared at writeback, so decode can detect RAW hazards;
- a flush input and an outstanding-producer counter.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads 0, ignores writes and never goes pending
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- raddr1  in  ADDR_W  read port 1 address
- raddr2  in  ADDR_W  read port 2 address
- rdata1  out  DATA_W  read port 1 data, combinational
- rdata2  out  DATA_W  read port 2 data, combinational
- busy1  out  1  raddr1 has an outstanding producer, combinational
- busy2  out  1  raddr2 has an outstanding producer, combinational
- sb_set  in  1  issue: mark sb_addr pending
- sb_addr  in  ADDR_W  destination of the issuing instruction
- flush  in  1  clear all pending bits (pipeline flush)
- pend_cnt  out  ADDR_W+1  number of pending entries, registered

## Operation
- Storage: DEPTH x DATA_W registers plus a DEPTH-bit pending vector.
- Reset (rst_n=0, asynchronous): all registers = 0, pending = 0, pend_cnt = 0. While in reset:
  - rdata1 = rdata2 = 0, except when BYPASS forwards wdata (see Read).
  - busy1 = busy2 = 0.
- Write: on the edge, if we=1, reg[waddr] <= wdata. If ZERO_REG=1 and waddr=0, the write is dropped.
- Read, port k:
  - If BYPASS=1, we=1, waddr=raddrk and not (ZERO_REG and waddr=0): rdatak = wdata.
  - Else if ZERO_REG=1 and raddrk=0: rdatak = 0.
  - Else: rdatak = reg[raddrk].
- Scoreboard next state per entry i, in priority order:
  1. flush → 0
  2. sb_set and sb_addr=i → 1
  3. we and waddr=i → 0
  4. otherwise hold
- The priority means a set and a clear to the same address in the same cycle leave the entry pending: the newer producer wins.
- With ZERO_REG=1, entry 0 is forced to 0 regardless.
- busyk = pending[raddrk] & ~(BYPASS & we & waddr=raddrk). A forwarded writeback resolves the hazard in the same cycle.
- busyk reflects the pre-edge state: an sb_set in cycle t does not raise busy until cycle t+1.
- pend_cnt: registered popcount of the next-state pending vector, updated on the same edge as pending. Range 0..DEPTH.

## Timing
- Write latency: 1 edge to storage, 0 cycles to readers when BYPASS=1. With BYPASS=0, reads see new data the cycle after the edge.
- Read latency: 0 cycles (combinational from raddr/storage/wdata).
- Scoreboard: set/clear visible on busy and pend_cnt 1 cycle after the edge.
- No handshake; the consumer stalls on busyk.
- Reset asserted mid-operation:
  - clears storage and pending asynchronously;
  - in-flight sb_set or we on the same cycle as reset is lost;
  - first edge after rst_n rises behaves normally.
- Boundaries:
  - all DEPTH entries pending → pend_cnt = DEPTH (no overflow, width ADDR_W+1);
  - sb_set to an already-pending entry keeps the bit set, count unchanged;
  - writeback to a non-pending entry leaves pend_cnt unchanged.

## Test plan
- Reset then read all addresses: rdata = 0, busy = 0, pend_cnt = 0. Then write 0xDEADBEEF to x5; the next cycle raddr1=5 gives 0xDEADBEEF.
- ZERO_REG: we=1, waddr=0, wdata=0xFFFFFFFF, raddr1=0 → rdata1=0 in the same and the next cycle; sb_set to 0 → busy1 stays 0, pend_cnt stays 0.
- Bypass: reg x7=0x11; same cycle we=1, waddr=7, wdata=0x22, raddr2=7 → rdata2=0x22 combinationally. With BYPASS=0 → 0x11, then 0x22 the next cycle.
- Scoreboard: sb_set x3 at t → busy1(raddr1=3)=1 and pend_cnt=1 at t+1; writeback x3 at t+2 → busy1=0 during t+2 (bypass); pend_cnt=0 at t+3.
- Simultaneous sb_set x4 and we x4 → x4 stays pending, data updated, pend_cnt unchanged at 1.
- Set x1..x31 over 31 cycles → pend_cnt=31; flush with sb_set x9 in the same cycle → pend_cnt=0, all busy=0. Async rst_n pulse mid-sequence → storage 0 immediately, without a clock edge.
